// File: rtl/ysyx_22040632_div_pkg.sv
// Shared types and helpers for the divider issue path.
// Holds op/state enums, most-negative constants and operand shaping.
package ysyx_22040632_div_pkg;

    typedef enum logic [1:0] {
        OP_DIV  = 2'd0,
        OP_DIVU = 2'd1,
        OP_REM  = 2'd2,
        OP_REMU = 2'd3
    } div_op_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } div_state_e;

    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
    localparam logic [31:0] MIN32 = 32'h8000_0000;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Bit 0 of the op encoding marks the unsigned variants.
    function automatic logic op_signed(input logic [1:0] op);
        return !op[0];
    endfunction

    // W ops only see the low word; widen it the way the op reads it.
    function automatic logic [63:0] eff_operand(
        input logic [63:0] src,
        input logic        word,
        input logic        sgn
    );
        if (!word) return src;
        return sgn ? sext32(src[31:0]) : {32'b0, src[31:0]};
    endfunction

endpackage

// File: rtl/ysyx_22040632_div_special.sv
// Divide-by-zero / signed-overflow detector with its architectural result.
// Ports: op, word, src1, src2 in; is_special, result (W-extended) out.
module ysyx_22040632_div_special
    import ysyx_22040632_div_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [1:0]      op,
    input  logic            word,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            is_special,
    output logic [XLEN-1:0] result
);

    logic        sgn;
    logic        rem;
    logic        div_zero;
    logic        ovf;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] raw;
    logic [63:0] min_eff;

    always_comb begin
        sgn      = op_signed(op);
        rem      = op[1];
        a        = eff_operand(src1, word, sgn);
        b        = eff_operand(src2, word, sgn);
        min_eff  = word ? sext32(MIN32) : MIN64;
        div_zero = (b == '0);
        ovf      = sgn && (b == '1) && (a == min_eff);
        is_special = div_zero || ovf;
        if (div_zero) begin
            raw = rem ? a : '1;
        end else begin
            raw = rem ? '0 : a;
        end
        result = word ? sext32(raw[31:0]) : raw;
    end

endmodule

// File: rtl/ysyx_22040632_div_issue.sv
// Issue side of the iterative divider: accepts ops, resolves specials,
// drives the divider handshake and holds the result for writeback.
// Ports: req_* from EXU, rsp_* to writeback, div_* / quotient /
// remainder to and from the divider, flush and async high reset rrst.
module ysyx_22040632_div_issue
    import ysyx_22040632_div_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int TAGW = 5
) (
    input  logic            clk,
    input  logic            rrst,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic            req_word,
    input  logic [XLEN-1:0] req_src1,
    input  logic [XLEN-1:0] req_src2,
    input  logic [TAGW-1:0] req_tag,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic [TAGW-1:0] rsp_tag,
    output logic            div_valid,
    input  logic            div_ready,
    output logic            div_signed,
    output logic            divw,
    output logic [XLEN-1:0] dividend,
    output logic [XLEN-1:0] divisor,
    output logic            div_flush,
    input  logic            div_out_valid,
    input  logic [XLEN-1:0] quotient,
    input  logic [XLEN-1:0] remainder
);

    div_state_e      state;
    div_state_e      state_next;
    logic [1:0]      op_q;
    logic            word_q;
    logic [TAGW-1:0] tag_q;
    logic [XLEN-1:0] dividend_q;
    logic [XLEN-1:0] divisor_q;
    logic [XLEN-1:0] rsp_data_q;
    logic [TAGW-1:0] rsp_tag_q;
    logic            sp_hit;
    logic [XLEN-1:0] sp_result;
    logic            accept;
    logic            capture;
    logic [XLEN-1:0] res_sel;
    logic [XLEN-1:0] res_fix;

    ysyx_22040632_div_special #(.XLEN(XLEN)) u_special (
        .op        (req_op),
        .word      (req_word),
        .src1      (req_src1),
        .src2      (req_src2),
        .is_special(sp_hit),
        .result    (sp_result)
    );

    assign accept  = (state == S_IDLE) && req_valid && !flush;
    assign capture = (state == S_WAIT) && !flush && div_out_valid;
    assign res_sel = op_q[1] ? remainder : quotient;
    // Upper word from the divider is not trusted for W ops.
    assign res_fix = word_q ? sext32(res_sel[31:0]) : res_sel;

    always_ff @(posedge clk or posedge rrst) begin
        if (rrst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = sp_hit ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (flush) begin
                    state_next = S_IDLE;
                end else if (div_ready) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    state_next = S_DRAIN;
                end else if (div_out_valid) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (flush || rsp_ready) begin
                    state_next = S_IDLE;
                end
            end
            S_DRAIN: begin
                // Wait out any in-flight strobe before reopening.
                if (div_ready && !div_out_valid) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == S_IDLE) && !flush;
        div_valid  = (state == S_ISSUE) && !flush;
        div_flush  = (state == S_WAIT) && flush;
        rsp_valid  = (state == S_DONE);
        div_signed = op_signed(op_q);
        divw       = word_q;
        dividend   = dividend_q;
        divisor    = divisor_q;
        rsp_data   = rsp_data_q;
        rsp_tag    = rsp_tag_q;
    end

    always_ff @(posedge clk or posedge rrst) begin
        if (rrst) begin
            op_q       <= '0;
            word_q     <= 1'b0;
            tag_q      <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            rsp_data_q <= '0;
            rsp_tag_q  <= '0;
        end else begin
            if (accept) begin
                op_q       <= req_op;
                word_q     <= req_word;
                tag_q      <= req_tag;
                dividend_q <= eff_operand(req_src1, req_word,
                                          op_signed(req_op));
                divisor_q  <= eff_operand(req_src2, req_word,
                                          op_signed(req_op));
                if (sp_hit) begin
                    rsp_data_q <= sp_result;
                    rsp_tag_q  <= req_tag;
                end
            end
            if (capture) begin
                rsp_data_q <= res_fix;
                rsp_tag_q  <= tag_q;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22040632_div_issue.sv
// Bench for the divider issue block: vector table, scoreboard queue,
// behavioural divider, flush / hold / reset sequences.
module tb_ysyx_22040632_div_issue;
    import ysyx_22040632_div_pkg::*;

    localparam int LAT = 6;

    logic        clk = 1'b0;
    logic        rrst;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic        req_word;
    logic [63:0] req_src1;
    logic [63:0] req_src2;
    logic [4:0]  req_tag;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_data;
    logic [4:0]  rsp_tag;
    logic        div_valid;
    logic        div_ready;
    logic        div_signed;
    logic        divw;
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic        div_flush;
    logic        div_out_valid;
    logic [63:0] quotient;
    logic [63:0] remainder;

    typedef struct {
        logic [1:0]  op;
        logic        word;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        logic        spec;
    } vec_t;

    typedef struct {
        logic [63:0] data;
        logic [4:0]  tag;
    } exp_t;

    vec_t vecs[13];
    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   hs_cnt = 0;
    int   dv_cnt = 0;
    int   fl_cnt = 0;
    logic force_strobe;

    always #5 clk = ~clk;

    ysyx_22040632_div_issue dut (
        .clk          (clk),
        .rrst         (rrst),
        .flush        (flush),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_word     (req_word),
        .req_src1     (req_src1),
        .req_src2     (req_src2),
        .req_tag      (req_tag),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_tag      (rsp_tag),
        .div_valid    (div_valid),
        .div_ready    (div_ready),
        .div_signed   (div_signed),
        .divw         (divw),
        .dividend     (dividend),
        .divisor      (divisor),
        .div_flush    (div_flush),
        .div_out_valid(div_out_valid),
        .quotient     (quotient),
        .remainder    (remainder)
    );

    // Behavioural divider; W results get junk in the upper word.
    initial begin : divider_model
        logic        busy;
        int          cnt;
        logic [63:0] mq;
        logic [63:0] mr;
        busy = 1'b0;
        cnt = 0;
        mq = '0;
        mr = '0;
        div_out_valid = 1'b0;
        quotient = '0;
        remainder = '0;
        forever begin
            @(negedge clk);
            div_out_valid = 1'b0;
            if (div_valid) dv_cnt++;
            if (div_flush) begin
                fl_cnt++;
                busy = 1'b0;
            end
            if (force_strobe) begin
                div_out_valid = 1'b1;
                quotient = 64'h0BAD_0BAD_0BAD_0BAD;
                remainder = 64'h0BAD_0BAD_0BAD_0BAD;
            end else if (busy) begin
                if (cnt == 0) begin
                    div_out_valid = 1'b1;
                    quotient = mq;
                    remainder = mr;
                    busy = 1'b0;
                end else begin
                    cnt--;
                end
            end
            if (div_valid && div_ready) begin
                hs_cnt++;
                if (div_signed) begin
                    mq = $signed(dividend) / $signed(divisor);
                    mr = $signed(dividend) % $signed(divisor);
                end else begin
                    mq = dividend / divisor;
                    mr = dividend % divisor;
                end
                if (divw) begin
                    mq[63:32] = 32'hDEAD_BEEF;
                    mr[63:32] = 32'hCAFE_F00D;
                end
                busy = 1'b1;
                cnt = LAT;
            end
        end
    end

    function automatic logic [63:0] ref_div(
        input logic [1:0] op, input logic w,
        input logic [63:0] a, input logic [63:0] b
    );
        logic        sg;
        logic        rm;
        logic [31:0] a32;
        logic [31:0] b32;
        logic [31:0] r32;
        logic [63:0] r;
        sg = !op[0];
        rm = op[1];
        a32 = a[31:0];
        b32 = b[31:0];
        if (w) begin
            if (b32 == 0) r32 = rm ? a32 : 32'hFFFF_FFFF;
            else if (sg && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF)
                r32 = rm ? 32'h0 : a32;
            else if (sg)
                r32 = rm ? $signed(a32) % $signed(b32)
                         : $signed(a32) / $signed(b32);
            else
                r32 = rm ? a32 % b32 : a32 / b32;
            return {{32{r32[31]}}, r32};
        end
        if (b == 0) r = rm ? a : '1;
        else if (sg && a == MIN64 && b == '1) r = rm ? '0 : a;
        else if (sg) r = rm ? $signed(a) % $signed(b)
                            : $signed(a) / $signed(b);
        else r = rm ? a % b : a / b;
        return r;
    endfunction

    task automatic check(input string name,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        check("req_ready_wait", 64'(req_ready), 64'd1);
    endtask

    task automatic drive(input logic [1:0] op, input logic w,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] tag);
        req_valid = 1'b1;
        req_op = op;
        req_word = w;
        req_src1 = a;
        req_src2 = b;
        req_tag = tag;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] op, input logic w,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] tag, input logic [63:0] exp,
                          input logic spec);
        int   n;
        int   hs0;
        int   dv0;
        exp_t e;
        wait_ready();
        hs0 = hs_cnt;
        dv0 = dv_cnt;
        sb.push_back('{data: exp, tag: tag});
        drive(op, w, a, b, tag);
        n = 0;
        while (!rsp_valid && n < 50) begin
            tick();
            n++;
        end
        e = sb.pop_front();
        if (!rsp_valid) begin
            tests++;
            fails++;
            $display("FAIL rsp_timeout tag %0d: rsp_valid 0, need 1", tag);
        end else begin
            check("rsp_data", rsp_data, e.data);
            check("rsp_tag", 64'(rsp_tag), 64'(e.tag));
            if (spec) begin
                check("special_latency", 64'(n), 64'd0);
                check("special_no_div_valid", 64'(dv_cnt - dv0), 64'd0);
            end else begin
                check("div_handshakes", 64'(hs_cnt - hs0), 64'd1);
            end
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rsp_valid_drop", 64'(rsp_valid), 64'd0);
        check("req_ready_back", 64'(req_ready), 64'd1);
    endtask

    initial begin : main
        logic [1:0]  op;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        int          fl0;
        int          n;

        vecs[0]  = '{OP_DIV, 1'b0, -64'sd7, 64'd2,
                     64'hFFFF_FFFF_FFFF_FFFD, 1'b0};
        vecs[1]  = '{OP_REM, 1'b0, -64'sd7, 64'd2,
                     64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vecs[2]  = '{OP_DIVU, 1'b0, 64'd5, 64'd0,
                     64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
        vecs[3]  = '{OP_REMU, 1'b0, 64'd5, 64'd0, 64'd5, 1'b1};
        vecs[4]  = '{OP_DIV, 1'b1, 64'h0000_0000_8000_0000,
                     64'hFFFF_FFFF_FFFF_FFFF,
                     64'hFFFF_FFFF_8000_0000, 1'b1};
        vecs[5]  = '{OP_REM, 1'b1, 64'h0000_0000_8000_0000,
                     64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1};
        vecs[6]  = '{OP_DIVU, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1,
                     64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
        vecs[7]  = '{OP_DIV, 1'b0, 64'h8000_0000_0000_0000,
                     64'hFFFF_FFFF_FFFF_FFFF,
                     64'h8000_0000_0000_0000, 1'b1};
        vecs[8]  = '{OP_REM, 1'b0, 64'h8000_0000_0000_0000,
                     64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1};
        vecs[9]  = '{OP_DIV, 1'b1, 64'h1234_5678_0000_0007,
                     64'h0000_0001_0000_0000,
                     64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
        vecs[10] = '{OP_REMU, 1'b1, 64'hFFFF_FFFF_8000_0003,
                     64'h10, 64'd3, 1'b0};
        vecs[11] = '{OP_DIVU, 1'b1, 64'h0000_0000_8000_0000,
                     64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0};
        vecs[12] = '{OP_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 1'b0};

        rrst = 1'b1;
        flush = 1'b0;
        req_valid = 1'b0;
        req_op = '0;
        req_word = 1'b0;
        req_src1 = '0;
        req_src2 = '0;
        req_tag = '0;
        rsp_ready = 1'b0;
        div_ready = 1'b1;
        force_strobe = 1'b0;
        tick();
        tick();
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_data", rsp_data, 64'd0);
        check("rst_rsp_tag", 64'(rsp_tag), 64'd0);
        check("rst_div_valid", 64'(div_valid), 64'd0);
        check("rst_div_flush", 64'(div_flush), 64'd0);
        check("rst_dividend", dividend, 64'd0);
        check("rst_divisor", divisor, 64'd0);
        rrst = 1'b0;
        tick();

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].op, vecs[i].word, vecs[i].a, vecs[i].b,
                   5'(i + 1), vecs[i].exp, vecs[i].spec);
        end

        for (int i = 0; i < 6; i++) begin
            op = 2'($urandom_range(0, 3));
            w = 1'($urandom_range(0, 1));
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if (w ? (b[31:0] == 0) : (b == 0)) b = 64'd3;
            if (w ? (b[31:0] == 32'hFFFF_FFFF) : (b == '1)) b = 64'd3;
            run_op(op, w, a, b, 5'(i + 16), ref_div(op, w, a, b), 1'b0);
        end

        // Flush two cycles into WAIT, then a stale strobe in DRAIN.
        wait_ready();
        drive(OP_DIV, 1'b0, 64'd100, 64'd7, 5'd20);
        tick();
        check("wait_div_valid_low", 64'(div_valid), 64'd0);
        tick();
        tick();
        fl0 = fl_cnt;
        flush = 1'b1;
        div_ready = 1'b0;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            force_strobe = (i == 1);
            check("drain_req_ready", 64'(req_ready), 64'd0);
            check("drain_rsp_valid", 64'(rsp_valid), 64'd0);
            tick();
        end
        force_strobe = 1'b0;
        check("div_flush_pulses", 64'(fl_cnt - fl0), 64'd1);
        check("drain_hold_req_ready", 64'(req_ready), 64'd0);
        div_ready = 1'b1;
        tick();
        check("drain_exit_req_ready", 64'(req_ready), 64'd1);
        run_op(OP_REMU, 1'b0, 64'd10, 64'd3, 5'd21, 64'd1, 1'b0);

        // Writeback stalls for five cycles.
        wait_ready();
        drive(OP_DIVU, 1'b0, 64'd100, 64'd7, 5'd22);
        n = 0;
        while (!rsp_valid && n < 50) begin
            tick();
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            check("hold_rsp_valid", 64'(rsp_valid), 64'd1);
            check("hold_rsp_data", rsp_data, 64'd14);
            check("hold_rsp_tag", 64'(rsp_tag), 64'd22);
            check("hold_req_ready", 64'(req_ready), 64'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("hold_release", 64'(rsp_valid), 64'd0);

        // Asynchronous reset while the divider request is pending.
        div_ready = 1'b0;
        drive(OP_DIV, 1'b0, 64'd9, 64'd2, 5'd23);
        check("pre_rst_div_valid", 64'(div_valid), 64'd1);
        #2;
        rrst = 1'b1;
        #1;
        check("mid_rst_div_valid", 64'(div_valid), 64'd0);
        check("mid_rst_req_ready", 64'(req_ready), 64'd1);
        check("mid_rst_dividend", dividend, 64'd0);
        tick();
        rrst = 1'b0;
        div_ready = 1'b1;
        tick();
        run_op(OP_DIV, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 64'd4, 5'd24,
               64'hFFFF_FFFF_FFFF_FFFC, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
